pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit for the Y86-64 five-stage pipe: generates stall/bubble for F/D/E/M/W regs and set_cc.
//  Pipeline regs (e.g. decode reg) have no reset, so after reset it runs a FLUSH phase injecting bubbles.
//  Freezes the pipe once a non-AOK status retires (HALT) until reset.
// PARAMETERS
//  FLUSH_CYC  3   bubble-injection cycles after reset deassert (>=1)
//  CNT_W      32  perf counter width (PERF_CNT_EN only)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  D_icode    in   4      icode in decode reg
//  d_srcA     in   4      decode srcA (F=RNONE)
//  d_srcB     in   4      decode srcB
//  E_icode    in   4      icode in execute reg
//  E_dstM     in   4      execute-stage load destination
//  e_Cnd      in   1      branch condition from execute
//  M_icode    in   4      icode in memory reg
//  m_stat     in   3      memory-stage status
//  W_stat     in   3      writeback-reg status
//  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble  out 1 each  register controls
//  set_cc     out  1      allow CC update
//  cpu_stat   out  3      registered processor status
//  halted     out  1      1 in HALT state
//  cyc_cnt, stall_cnt, flush_cnt  out CNT_W  perf counters (PERF_CNT_EN only)
// BEHAVIOUR
//  Codes: stat AOK=1 HLT=2 ADR=3 INS=4; icode JXX=7 RET=9 MRMOVQ=5 POPQ=B OPQ=6.
//  FSM: FLUSH -> RUN -> HALT. Reset: state=FLUSH, flush ctr=FLUSH_CYC-1, cpu_stat=AOK, halted=0.
//  FLUSH: F_stall=1, D/E/M/W_bubble=1, D_stall=W_stall=0, set_cc=0; ctr decrements, ->RUN when 0
//   (exactly FLUSH_CYC cycles). Pipeline inputs ignored.
//  RUN (outputs combinational from inputs, same cycle):
//   lu  = (E_icode==MRMOVQ|POPQ) && E_dstM!=F && (E_dstM==d_srcA || E_dstM==d_srcB)
//   ret = RET in {D_icode,E_icode,M_icode}; mis = E_icode==JXX && !e_Cnd
//   exc = m_stat in {ADR,INS,HLT}; wex = W_stat in {ADR,INS,HLT}
//   F_stall=lu|ret; D_stall=lu; D_bubble=mis|(ret&!lu); E_bubble=mis|lu
//   M_bubble=exc|wex; W_stall=wex; W_bubble=0
//   set_cc = E_icode==OPQ && !exc && !wex
//  lu+ret same cycle: D stalls, no D bubble. mis+lu cannot co-occur; if both, E_bubble=1, D_bubble=1.
//  RUN->HALT on posedge where wex=1; cpu_stat<=W_stat that edge. In RUN cpu_stat tracks W_stat (AOK).
//  HALT: F_stall=D_stall=W_stall=1, M_bubble=1, others 0, set_cc=0, halted=1, cpu_stat held. Exit only by reset.
//  Reset asserted in any state (mid-flush, mid-run, halted) -> FLUSH next edge, counter reloaded.
//  No output X: all decode on 4/3-bit compares; unknown stat codes (0,5-7) treated as AOK-like (no freeze).
// CONFIGURATION
//  PERF_CNT_EN defined: cyc_cnt ++ every RUN cycle; stall_cnt ++ RUN cycles with F_stall;
//   flush_cnt ++ RUN cycles with D_bubble&mis. All clear on reset, wrap at 2^CNT_W, frozen in FLUSH/HALT.
//  PERF_CNT_EN undefined: counter ports and logic absent; control behaviour identical.
// TESTING
//  1 reset 1 cycle, FLUSH_CYC=3 -> bubbles+F_stall for exactly 3 cycles, then RUN, cpu_stat=1.
//  2 E_icode=5, E_dstM=3, d_srcB=3 -> F_stall=1 D_stall=1 E_bubble=1 D_bubble=0; E_dstM=F -> none.
//  3 E_icode=7, e_Cnd=0 -> D_bubble=1 E_bubble=1 F_stall=0; e_Cnd=1 -> all 0.
//  4 D_icode=9 alone -> F_stall=1 D_bubble=1; with lu same cycle -> D_stall=1, D_bubble=0.
//  5 m_stat=3 with E_icode=6 -> set_cc=0 M_bubble=1; next W_stat=3 -> HALT, cpu_stat=3, halted=1 held.
//  6 reset asserted in HALT -> FLUSH next edge, halted=0, cpu_stat=1; with PERF_CNT_EN counters=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, post-reset flush and halt freeze.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYC = 3
`ifdef PERF_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       W_bubble,
    output logic       set_cc,
    output logic [2:0] cpu_stat,
    output logic       halted
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned CTR_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       cpu_stat_q, cpu_stat_d;
    logic             halted_q, halted_d;

    logic lu, ret, mis, exc, wex;

    // Hazard detection; only consumed while running
    always_comb begin
        lu  = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != R_NONE)
              && (E_dstM == d_srcA || E_dstM == d_srcB);
        ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mis = (E_icode == I_JXX) && !e_Cnd;
        exc = (m_stat == STAT_ADR) || (m_stat == STAT_INS) || (m_stat == STAT_HLT);
        wex = (W_stat == STAT_ADR) || (W_stat == STAT_INS) || (W_stat == STAT_HLT);
    end

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        cpu_stat_d = cpu_stat_q;
        halted_d   = halted_q;
        F_stall    = 1'b0;
        D_stall    = 1'b0;
        D_bubble   = 1'b0;
        E_bubble   = 1'b0;
        M_bubble   = 1'b0;
        W_stall    = 1'b0;
        W_bubble   = 1'b0;
        set_cc     = 1'b0;
        case (state_q)
            ST_FLUSH: begin
                F_stall    = 1'b1;
                D_bubble   = 1'b1;
                E_bubble   = 1'b1;
                M_bubble   = 1'b1;
                W_bubble   = 1'b1;
                cpu_stat_d = STAT_AOK;
                halted_d   = 1'b0;
                if (ctr_q == '0) state_d = ST_RUN;
                else             ctr_d   = ctr_q - CTR_W'(1);
            end
            ST_RUN: begin
                F_stall  = lu | ret;
                D_stall  = lu;
                D_bubble = mis | (ret & !lu);
                E_bubble = mis | lu;
                M_bubble = exc | wex;
                W_stall  = wex;
                set_cc   = (E_icode == I_OPQ) && !exc && !wex;
                // A faulting instruction reaching writeback freezes the machine
                if (wex) begin
                    state_d    = ST_HALT;
                    cpu_stat_d = W_stat;
                    halted_d   = 1'b1;
                end else begin
                    cpu_stat_d = STAT_AOK;
                end
            end
            ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                M_bubble = 1'b1;
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_FLUSH;
            ctr_q      <= CTR_W'(FLUSH_CYC - 1);
            cpu_stat_q <= STAT_AOK;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            cpu_stat_q <= cpu_stat_d;
            halted_q   <= halted_d;
        end
    end

    assign cpu_stat = cpu_stat_q;
    assign halted   = halted_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Counters advance only on running cycles and wrap naturally
    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_RUN) begin
            cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
            if (F_stall)         stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (D_bubble && mis) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized
// traffic with random resets, checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned FLUSH_CYC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc;
    logic [2:0] cpu_stat;
    logic       halted;
`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    pipe_ctrl #(.FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .W_bubble(W_bubble), .set_cc(set_cc), .cpu_stat(cpu_stat), .halted(halted)
`ifdef PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: cycles of flush left, halt flag, retired status, counters
    int          m_flush_left = 0;
    bit          m_halt       = 1'b0;
    logic [2:0]  m_stat_r     = 3'd1;
    logic [31:0] m_cyc = '0, m_stall = '0, m_flush = '0;

    function automatic bit bad(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,W_bubble,set_cc,cpu_stat,halted}
    function automatic logic [11:0] model_out();
        bit lu, rt, mis, ex, wx;
        logic [7:0] c;
        if (m_flush_left > 0)  c = 8'b1011_1010;
        else if (m_halt)       c = 8'b1100_1100;
        else begin
            lu  = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                  (E_dstM == d_srcA || E_dstM == d_srcB);
            rt  = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
            mis = (E_icode == 4'h7) && !e_Cnd;
            ex  = bad(m_stat);
            wx  = bad(W_stat);
            c = {lu | rt, lu, mis | (rt & !lu), mis | lu, ex | wx, wx, 1'b0,
                 (E_icode == 4'h6) && !ex && !wx};
        end
        return {c, m_stat_r, m_halt};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble,
                set_cc, cpu_stat, halted};
    endfunction

    // Advance one clock and update the model with the inputs sampled at that edge
    task automatic tick();
        logic [11:0] e;
        e = model_out();
        @(posedge clk);
        if (reset) begin
            m_flush_left = FLUSH_CYC;
            m_halt = 1'b0; m_stat_r = 3'd1;
            m_cyc = '0; m_stall = '0; m_flush = '0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (!m_halt) begin
            m_cyc++;
            if (e[11]) m_stall++;
            if (E_icode == 4'h7 && !e_Cnd) m_flush++;
            if (bad(W_stat)) begin m_halt = 1'b1; m_stat_r = W_stat; end
        end
        #1;
    endtask

    function automatic logic [3:0] pick_icode();
        logic [3:0] tbl [8];
        tbl = '{4'h0, 4'h2, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h3};
        return tbl[$urandom_range(0, 7)];
    endfunction

    function automatic logic [3:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction

    task automatic drive_rand(input bit allow_freeze);
        logic [2:0] ok [5];
        ok = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7};
        D_icode = pick_icode(); E_icode = pick_icode(); M_icode = pick_icode();
        d_srcA = pick_reg(); d_srcB = pick_reg(); E_dstM = pick_reg();
        e_Cnd  = 1'($urandom_range(0, 1));
        m_stat = 3'($urandom_range(0, 7));
        W_stat = (allow_freeze && $urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4))
                                                             : ok[$urandom_range(0, 4)];
    endtask

    task automatic drive_idle();
        D_icode = 4'h0; E_icode = 4'h0; M_icode = 4'h0;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b0;
        m_stat = 3'd1; W_stat = 3'd1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        drive_rand(1'b1);
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < FLUSH_CYC + 2; i++) begin
            if (i < FLUSH_CYC) drive_rand(1'b1); else drive_idle();
            @(negedge clk); e = model_out();
            n_checks++;
            if (dut_vec() !== e) begin
                n_err++; $display("FAIL reset_seq cyc%0d: got %b want %b", i, dut_vec(), e);
            end
            n_checks++;
            if ((i < FLUSH_CYC) !== (F_stall && D_bubble && E_bubble && M_bubble && W_bubble)) begin
                n_err++; $display("FAIL flush_len cyc%0d: got F_stall=%b W_bubble=%b", i, F_stall, W_bubble);
            end
            tick();
        end
        n_checks++;
        if (cpu_stat !== 3'd1 || halted !== 1'b0) begin
            n_err++; $display("FAIL run_stat: got stat=%0d halted=%b want 1/0", cpu_stat, halted);
        end
    endtask

    task automatic test_load_use();
        drive_idle();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
        @(negedge clk);
        n_checks++;
        if ({F_stall, D_stall, E_bubble, D_bubble} !== 4'b1110 || model_out() !== dut_vec()) begin
            n_err++; $display("FAIL load_use: got %b want %b", dut_vec(), model_out());
        end
        tick();
        E_dstM = 4'hF; d_srcB = 4'hF;
        @(negedge clk);
        n_checks++;
        if ({F_stall, D_stall, E_bubble, D_bubble} !== 4'b0000) begin
            n_err++; $display("FAIL load_rnone: got %b want 0000", {F_stall, D_stall, E_bubble, D_bubble});
        end
        tick();
    endtask

    task automatic test_mispredict();
        for (int c = 0; c < 2; c++) begin
            drive_idle();
            E_icode = 4'h7; e_Cnd = 1'(c);
            @(negedge clk);
            n_checks++;
            if ({D_bubble, E_bubble, F_stall} !== ((c == 0) ? 3'b110 : 3'b000)) begin
                n_err++; $display("FAIL mispredict cnd=%0d: got %b", c, {D_bubble, E_bubble, F_stall});
            end
            tick();
        end
    endtask

    task automatic test_ret();
        drive_idle();
        D_icode = 4'h9;
        @(negedge clk);
        n_checks++;
        if ({F_stall, D_stall, D_bubble} !== 3'b101) begin
            n_err++; $display("FAIL ret_alone: got %b want 101", {F_stall, D_stall, D_bubble});
        end
        tick();
        E_icode = 4'hB; E_dstM = 4'h2; d_srcA = 4'h2;
        @(negedge clk);
        n_checks++;
        if ({F_stall, D_stall, D_bubble, E_bubble} !== 4'b1101) begin
            n_err++; $display("FAIL ret_lu: got %b want 1101", {F_stall, D_stall, D_bubble, E_bubble});
        end
        tick();
    endtask

    task automatic test_random();
        logic [11:0] e;
        for (int i = 0; i < 400; i++) begin
            drive_rand(1'b1);
            reset = ($urandom_range(0, 24) == 0);
            @(negedge clk); e = model_out();
            n_checks++;
            if (dut_vec() !== e) begin
                n_err++; $display("FAIL random cyc%0d: got %b want %b", i, dut_vec(), e);
            end
`ifdef PERF_CNT_EN
            n_checks++;
            if ({cyc_cnt, stall_cnt, flush_cnt} !== {m_cyc, m_stall, m_flush}) begin
                n_err++; $display("FAIL perf cyc%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                                  cyc_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
            end
`endif
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_halt();
        reset = 1'b1; tick(); reset = 1'b0;
        drive_idle();
        repeat (FLUSH_CYC) tick();
        E_icode = 4'h6; m_stat = 3'd3;
        @(negedge clk);
        n_checks++;
        if (set_cc !== 1'b0 || M_bubble !== 1'b1) begin
            n_err++; $display("FAIL exc_mem: got set_cc=%b M_bubble=%b want 0/1", set_cc, M_bubble);
        end
        tick();
        m_stat = 3'd1; W_stat = 3'd3;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_rand(1'b1);
            @(negedge clk);
            n_checks++;
            if (halted !== 1'b1 || cpu_stat !== 3'd3 || dut_vec() !== model_out()) begin
                n_err++; $display("FAIL halt_hold cyc%0d: got %b want %b", i, dut_vec(), model_out());
            end
            tick();
        end
    endtask

    task automatic test_reset_in_halt();
        reset = 1'b1; tick(); reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b0 || cpu_stat !== 3'd1 || F_stall !== 1'b1 || W_bubble !== 1'b1) begin
            n_err++; $display("FAIL halt_reset: got halted=%b stat=%0d F_stall=%b", halted, cpu_stat, F_stall);
        end
`ifdef PERF_CNT_EN
        n_checks++;
        if ({cyc_cnt, stall_cnt, flush_cnt} !== 96'd0) begin
            n_err++; $display("FAIL perf_clear: got %0d/%0d/%0d want 0", cyc_cnt, stall_cnt, flush_cnt);
        end
`endif
        tick();
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret();
        test_random();
        test_halt();
        test_reset_in_halt();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
